// File: rtl/pipe_xm_stage_pkg.sv
// pipe_defs: shared constants and FSM state type for the X/M pipeline stage
package pipe_defs;
    localparam int DATA_W = 16;
    localparam int OPX_W = 7;
    localparam int REG_W = 3;
    localparam logic [6:0] NOP_OPX = 7'b0000100;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} xm_state_t;
endpackage

// File: rtl/pipe_xm_stage_mem_fsm.sv
// xm_mem_fsm: data-memory handshake, timeout counter and upstream stall for the X/M stage
module xm_mem_fsm
    import pipe_defs::*;
#(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic cap_mem,
    input  logic m_mem_rd,
    input  logic m_mem_wr,
    input  logic mem_done,
    output logic mem_rd,
    output logic mem_wr,
    output logic stall_out,
    output logic timeout
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
    xm_state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic busy, done;
    // Outputs and next state; a timeout is treated exactly like a completed access
    always_comb begin
        busy = state != IDLE;
        timeout = state == WAIT && !mem_done && cnt == CNT_W'(MEM_TIMEOUT - 1);
        done = mem_done | timeout;
        stall_out = busy & ~done;
        mem_rd = busy & m_mem_rd;
        mem_wr = busy & m_mem_wr;
        state_nx = (!busy || done) ? (cap_mem ? REQ : IDLE) : WAIT;
    end
    // State register and REQ+WAIT cycle counter (REQ counts as cycle 0)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= state_nx != WAIT ? '0 : state == WAIT ? cnt + 1'b1 : CNT_W'(1);
        end
    end
endmodule

// File: rtl/pipe_xm_stage.sv
// pipe_xm_stage: X/M capture registers, sticky error and optional stall counter (XM_STALL_CNT_EN)
module pipe_xm_stage
    import pipe_defs::*;
#(
    parameter int DATA_W = pipe_defs::DATA_W,
    parameter int OPX_W = pipe_defs::OPX_W,
    parameter int REG_W = pipe_defs::REG_W,
    parameter logic [OPX_W-1:0] NOP_OPX = OPX_W'(pipe_defs::NOP_OPX),
    parameter int MEM_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x_valid,
    input  logic [OPX_W-1:0]  x_instr_op_ext,
    input  logic [DATA_W-1:0] x_alu_result,
    input  logic [DATA_W-1:0] x_mem_data,
    input  logic              x_mem_rd,
    input  logic              x_mem_wr,
    input  logic              x_halt,
    input  logic              x_write_en,
    input  logic [REG_W-1:0]  x_write_reg_sel,
    input  logic              x_write_set,
    input  logic              x_err,
    input  logic              mem_done,
    output logic [OPX_W-1:0]  m_instr_op_ext,
    output logic [DATA_W-1:0] m_alu_result,
    output logic [DATA_W-1:0] m_mem_data,
    output logic              m_halt,
    output logic              m_write_en,
    output logic [REG_W-1:0]  m_write_reg_sel,
    output logic              m_write_set,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              stall_out,
    output logic              err_out,
    output logic [15:0]       stall_cycles
);
    logic m_mem_rd, m_mem_wr, timeout, cap_mem;
    assign cap_mem = x_valid & (x_mem_rd | x_mem_wr);
    xm_mem_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
        .clk(clk),
        .rst(rst),
        .cap_mem(cap_mem),
        .m_mem_rd(m_mem_rd),
        .m_mem_wr(m_mem_wr),
        .mem_done(mem_done),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .stall_out(stall_out),
        .timeout(timeout)
    );
    // Capture X results when not stalled; an invalid X slot becomes a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            m_instr_op_ext <= NOP_OPX;
            m_alu_result <= '0;
            m_mem_data <= '0;
            m_halt <= 1'b0;
            m_write_en <= 1'b0;
            m_write_reg_sel <= '0;
            m_write_set <= 1'b0;
            m_mem_rd <= 1'b0;
            m_mem_wr <= 1'b0;
        end else if (!stall_out) begin
            m_instr_op_ext <= x_valid ? x_instr_op_ext : NOP_OPX;
            m_alu_result <= x_alu_result;
            m_mem_data <= x_mem_data;
            m_halt <= x_valid & x_halt;
            m_write_en <= x_valid & x_write_en;
            m_write_reg_sel <= x_write_reg_sel;
            m_write_set <= x_write_set;
            m_mem_rd <= x_valid & x_mem_rd;
            m_mem_wr <= x_valid & x_mem_wr;
        end
    end
    // Sticky error: upstream error, illegal rd+wr, or memory timeout
    always_ff @(posedge clk) begin
        if (rst) err_out <= 1'b0;
        else err_out <= err_out | timeout | (~stall_out & x_valid & (x_err | (x_mem_rd & x_mem_wr)));
    end
`ifdef XM_STALL_CNT_EN
    // Saturating count of stalled clocks
    always_ff @(posedge clk) begin
        if (rst) stall_cycles <= 16'h0000;
        else if (stall_out && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
    end
`else
    assign stall_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_xm_stage.sv
// tb_pipe_xm_stage: directed + random checks of pipe_xm_stage against a transaction-level model
module tb_pipe_xm_stage;
    localparam int MT = 8;
    logic clk = 1'b0;
    logic rst, x_valid, x_mem_rd, x_mem_wr, x_halt, x_write_en, x_write_set, x_err, mem_done;
    logic [6:0] x_instr_op_ext;
    logic [15:0] x_alu_result, x_mem_data;
    logic [2:0] x_write_reg_sel;
    logic [6:0] m_instr_op_ext;
    logic [15:0] m_alu_result, m_mem_data, stall_cycles;
    logic m_halt, m_write_en, m_write_set, mem_rd, mem_wr, stall_out, err_out;
    logic [2:0] m_write_reg_sel;
    int checks = 0;
    int failures = 0;
    // Model: an outstanding access and its age in cycles since it was first requested
    bit busy;
    int age;
    logic [6:0] e_op;
    logic [15:0] e_alu, e_data;
    logic e_halt, e_we, e_set, e_rd, e_wr, e_err;
    logic [2:0] e_sel;
    int e_sc;

    always #5 clk = ~clk;

    pipe_xm_stage #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .x_valid(x_valid), .x_instr_op_ext(x_instr_op_ext),
        .x_alu_result(x_alu_result), .x_mem_data(x_mem_data), .x_mem_rd(x_mem_rd),
        .x_mem_wr(x_mem_wr), .x_halt(x_halt), .x_write_en(x_write_en),
        .x_write_reg_sel(x_write_reg_sel), .x_write_set(x_write_set), .x_err(x_err),
        .mem_done(mem_done), .m_instr_op_ext(m_instr_op_ext), .m_alu_result(m_alu_result),
        .m_mem_data(m_mem_data), .m_halt(m_halt), .m_write_en(m_write_en),
        .m_write_reg_sel(m_write_reg_sel), .m_write_set(m_write_set), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .stall_out(stall_out), .err_out(err_out), .stall_cycles(stall_cycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; age = 0; e_op = 7'b0000100; e_alu = 0; e_data = 0; e_halt = 0; e_we = 0;
        e_set = 0; e_rd = 0; e_wr = 0; e_err = 0; e_sel = 0; e_sc = 0;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [15:0] alu, input logic done);
        x_valid = v; x_mem_rd = rd; x_mem_wr = wr; x_alu_result = alu; mem_done = done;
        x_instr_op_ext = 7'($urandom); x_mem_data = 16'($urandom); x_halt = 1'($urandom);
        x_write_en = 1'($urandom); x_write_reg_sel = 3'($urandom); x_write_set = 1'($urandom);
        x_err = 1'b0;
    endtask

    // Compare at the falling edge, then advance the model at the rising edge
    task automatic step();
        bit done_m, ex_stall;
        @(negedge clk);
        done_m = busy && (mem_done || age == MT - 1);
        ex_stall = busy && !done_m;
        chk("stall_out", 32'(stall_out), 32'(ex_stall));
        chk("mem_rd", 32'(mem_rd), 32'(busy && e_rd));
        chk("mem_wr", 32'(mem_wr), 32'(busy && e_wr));
        chk("err_out", 32'(err_out), 32'(e_err));
        chk("m_op", 32'(m_instr_op_ext), 32'(e_op));
        chk("m_alu", 32'(m_alu_result), 32'(e_alu));
        chk("m_data", 32'(m_mem_data), 32'(e_data));
        chk("m_halt", 32'(m_halt), 32'(e_halt));
        chk("m_we", 32'(m_write_en), 32'(e_we));
        chk("m_sel", 32'(m_write_reg_sel), 32'(e_sel));
        chk("m_set", 32'(m_write_set), 32'(e_set));
`ifdef XM_STALL_CNT_EN
        chk("stall_cycles", 32'(stall_cycles), 32'(e_sc));
`else
        chk("stall_cycles", 32'(stall_cycles), 32'h0);
`endif
        @(posedge clk);
        if (rst) model_reset();
        else if (ex_stall) begin
            age++;
            if (e_sc < 65535) e_sc++;
        end else begin
            if (busy && !mem_done) e_err = 1;
            if (x_valid && (x_err || (x_mem_rd && x_mem_wr))) e_err = 1;
            e_op = x_valid ? x_instr_op_ext : 7'b0000100;
            e_alu = x_alu_result; e_data = x_mem_data; e_sel = x_write_reg_sel; e_set = x_write_set;
            e_halt = x_valid && x_halt; e_we = x_valid && x_write_en;
            e_rd = x_valid && x_mem_rd; e_wr = x_valid && x_mem_wr;
            busy = x_valid && (x_mem_rd || x_mem_wr);
            age = 0;
        end
        #1;
    endtask

    initial begin
        int r;
        rst = 1'b1;
        drive(0, 0, 0, 16'h0, 0);
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        step();
        // Load hit in the REQ cycle
        drive(1, 1, 0, 16'h0040, 0); step();
        drive(0, 0, 0, 16'h0, 1); step();
        drive(0, 0, 0, 16'h0, 0); step();
        // Store completing 4 cycles after REQ entry; next instruction waits in X
        drive(1, 0, 1, 16'h1234, 0); step();
        drive(1, 0, 0, 16'h5555, 0); step();
        step(); step();
        mem_done = 1'b1; step();
        drive(0, 0, 0, 16'h0, 0); step();
        // Back-to-back load hits
        drive(1, 1, 0, 16'h0100, 0); step();
        drive(1, 1, 0, 16'h0102, 1); step();
        drive(0, 0, 0, 16'h0, 1); step();
        drive(0, 0, 0, 16'h0, 0); step();
        // Timeout: memory never answers
        drive(1, 1, 0, 16'h0200, 0); step();
        drive(1, 0, 0, 16'h0300, 0);
        repeat (MT + 4) step();
        // Upstream error and illegal rd+wr after a reset
        rst = 1'b1; step();
        rst = 1'b0; drive(1, 0, 0, 16'h0400, 0); x_err = 1'b1; step();
        drive(0, 0, 0, 16'h0, 0); step();
        rst = 1'b1; step();
        rst = 1'b0; drive(1, 1, 1, 16'h0500, 0); step();
        drive(0, 0, 0, 16'h0, 1); step();
        step();
        // Random traffic
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 3) != 0), r < 5 || r == 15, (r >= 5 && r < 9) || r == 15,
                  16'($urandom), $urandom_range(0, 2) == 0);
            x_err = $urandom_range(0, 19) == 0;
            rst = $urandom_range(0, 63) == 0;
            step();
        end
        rst = 1'b1; drive(0, 0, 0, 16'h0, 0); step();
        rst = 1'b0; step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
